// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the SimpleCPU multi-cycle control sequencer:
// opcode/funct constants, state encoding, datapath select encodings and
// the bundled control-output record.
package mc_ctrl_pkg;

    // Opcodes understood by the sequencer
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    // R-type function codes
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // Width of the memory watchdog counter
    localparam int unsigned WD_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_EXEC      = 4'd7,
        ST_ALU_WB    = 4'd8,
        ST_ADDI_EXEC = 4'd9,
        ST_ADDI_WB   = 4'd10,
        ST_BRANCH    = 4'd11,
        ST_JUMP      = 4'd12,
        ST_ILLEGAL   = 4'd13
    } state_e;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        SRCB_REG    = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } src_b_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_e;

    // Every datapath select and strobe driven by the sequencer in one cycle
    typedef struct packed {
        logic      mem_req;
        logic      mem_we;
        logic      iord;
        logic      ir_we;
        logic      pc_we;
        pc_src_e   pc_src;
        logic      alu_src_a;
        src_b_e    alu_src_b;
        alu_ctrl_e alu_ctrl;
        logic      reg_we;
        logic      reg_dst;
        logic      mem_to_reg;
        logic      illegal;
        logic      bus_err;
    } ctrl_t;

    // States that hold a request open on the memory port
    function automatic logic is_req_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// R-type function decoder: maps funct onto an ALU operation and flags
// function codes the datapath does not implement.
module alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output alu_ctrl_e  alu_ctrl_o,
    output logic       funct_ok_o
);

    // Pure table lookup; unknown codes keep a harmless add and drop the valid flag.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can leave it unassigned (which would infer a latch).
        alu_ctrl_o = ALU_ADD;
        funct_ok_o = 1'b1;
        case (funct_i)
            FN_ADD:  alu_ctrl_o = ALU_ADD;
            FN_SUB:  alu_ctrl_o = ALU_SUB;
            FN_AND:  alu_ctrl_o = ALU_AND;
            FN_OR:   alu_ctrl_o = ALU_OR;
            FN_SLT:  alu_ctrl_o = ALU_SLT;
            default: funct_ok_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for SimpleCPU. Steps each instruction through
// fetch/decode/execute/memory/writeback, decodes all datapath controls from
// the state register, and guards memory requests with an ack watchdog.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    // Maximum wait cycles for a memory ack (1..255); 0 disables the watchdog.
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ack_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       iord_o,
    output logic       ir_we_o,
    output logic       pc_we_o,
    output logic [1:0] pc_src_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_ctrl_o,
    output logic       reg_we_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       illegal_o,
    output logic       bus_err_o,
    output logic [3:0] state_o
);

    localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(TIMEOUT);
    localparam logic            WD_ENABLE = (TIMEOUT != 0);

    state_e          state_q, state_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    ctrl_t           ctrl;
    alu_ctrl_e       exec_alu;
    logic            funct_ok;
    logic            in_req;
    logic            wd_expire;

    alu_dec u_alu_dec (
        .funct_i    (funct_i),
        .alu_ctrl_o (exec_alu),
        .funct_ok_o (funct_ok)
    );

    // The expiry cycle still shows the request, so a late ack in that cycle wins.
    assign in_req    = is_req_state(state_q);
    assign wd_expire = WD_ENABLE && in_req && !mem_ack_i && (wd_cnt_q == WD_LIMIT);

    // Watchdog next value: count un-acked wait cycles, zero on any other cycle.
    always_comb begin
        wd_cnt_d = '0;
        if (in_req && !mem_ack_i && !wd_expire) begin
            wd_cnt_d = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + 1'b1;
        end
    end

    // Next-state and control decode; strobes default to 0 in every state.
    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                if (mem_ack_i) begin
                    ctrl.ir_we = 1'b1;
                    ctrl.pc_we = 1'b1;
                    state_d    = ST_DECODE;
                end else if (wd_expire) begin
                    ctrl.bus_err = 1'b1;
                    state_d      = ST_IDLE;
                end
            end

            ST_DECODE: begin
                // Branch target is computed speculatively into ALUOut here.
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_ctrl  = ALU_ADD;
                case (op_i)
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_ADDI:      state_d = ST_ADDI_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_ILLEGAL;
                endcase
            end

            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_ctrl  = ALU_ADD;
                state_d        = (op_i == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            end

            ST_MEM_READ: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                if (mem_ack_i) begin
                    state_d = ST_MEM_WB;
                end else if (wd_expire) begin
                    ctrl.bus_err = 1'b1;
                    state_d      = ST_IDLE;
                end
            end

            ST_MEM_WB: begin
                ctrl.reg_we     = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = ST_FETCH;
            end

            ST_MEM_WRITE: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.iord    = 1'b1;
                if (mem_ack_i) begin
                    state_d = ST_FETCH;
                end else if (wd_expire) begin
                    ctrl.bus_err = 1'b1;
                    state_d      = ST_IDLE;
                end
            end

            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_ctrl  = exec_alu;
                state_d        = funct_ok ? ST_ALU_WB : ST_ILLEGAL;
            end

            ST_ALU_WB: begin
                ctrl.reg_we  = 1'b1;
                ctrl.reg_dst = 1'b1;
                state_d      = ST_FETCH;
            end

            ST_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_ctrl  = ALU_ADD;
                state_d        = ST_ADDI_WB;
            end

            ST_ADDI_WB: begin
                ctrl.reg_we = 1'b1;
                state_d     = ST_FETCH;
            end

            ST_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_ctrl  = ALU_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.pc_we     = zero_i;
                state_d        = ST_FETCH;
            end

            ST_JUMP: begin
                ctrl.pc_src = PCSRC_JUMP;
                ctrl.pc_we  = 1'b1;
                state_d     = ST_FETCH;
            end

            ST_ILLEGAL: begin
                // PC already advanced in FETCH, so the bad instruction is skipped.
                ctrl.illegal = 1'b1;
                state_d      = ST_FETCH;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and watchdog registers; reset drops to IDLE from any state at once.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: reset is asynchronous so an outstanding request is abandoned without waiting for a clock edge.
        if (reset) begin
            state_q  <= ST_IDLE;
            wd_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign mem_req_o    = ctrl.mem_req;
    assign mem_we_o     = ctrl.mem_we;
    assign iord_o       = ctrl.iord;
    assign ir_we_o      = ctrl.ir_we;
    assign pc_we_o      = ctrl.pc_we;
    assign pc_src_o     = ctrl.pc_src;
    assign alu_src_a_o  = ctrl.alu_src_a;
    assign alu_src_b_o  = ctrl.alu_src_b;
    assign alu_ctrl_o   = ctrl.alu_ctrl;
    assign reg_we_o     = ctrl.reg_we;
    assign reg_dst_o    = ctrl.reg_dst;
    assign mem_to_reg_o = ctrl.mem_to_reg;
    assign illegal_o    = ctrl.illegal;
    assign bus_err_o    = ctrl.bus_err;
    assign state_o      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl. Each instruction is expanded by a
// behavioural model into its expected per-cycle control trace, the DUT is
// driven by a memory that acks after a chosen delay, and the observed trace
// is compared field by field (selects only where the instruction defines them).
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    localparam int unsigned T = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op_i, funct_i;
    logic       zero_i, mem_ack_i;
    logic       mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o;
    logic [1:0] pc_src_o, alu_src_b_o;
    logic       alu_src_a_o;
    logic [2:0] alu_ctrl_o;
    logic       reg_we_o, reg_dst_o, mem_to_reg_o, illegal_o, bus_err_o;
    logic [3:0] state_o;

    mc_ctrl #(.TIMEOUT(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_i         (op_i),
        .funct_i      (funct_i),
        .zero_i       (zero_i),
        .mem_ack_i    (mem_ack_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .iord_o       (iord_o),
        .ir_we_o      (ir_we_o),
        .pc_we_o      (pc_we_o),
        .pc_src_o     (pc_src_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_ctrl_o   (alu_ctrl_o),
        .reg_we_o     (reg_we_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .illegal_o    (illegal_o),
        .bus_err_o    (bus_err_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       src_a;
        logic [1:0] src_b;
        logic [2:0] alu;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
        logic       bus_err;
    } obs_t;

    typedef struct {
        obs_t v;
        obs_t m;
    } exp_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         fd;
        int         md;
        int         cycles;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    obs_t got_q[$];
    vec_t vecs[19];

    logic [5:0] legal_ops[6] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    logic [5:0] bad_ops[4]   = '{6'h01, 6'h3F, 6'h10, 6'h2C};
    logic [5:0] functs[7]    = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, 6'h07, 6'h21};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.mem_req    = mem_req_o;
        o.mem_we     = mem_we_o;
        o.iord       = iord_o;
        o.ir_we      = ir_we_o;
        o.pc_we      = pc_we_o;
        o.pc_src     = pc_src_o;
        o.src_a      = alu_src_a_o;
        o.src_b      = alu_src_b_o;
        o.alu        = alu_ctrl_o;
        o.reg_we     = reg_we_o;
        o.reg_dst    = reg_dst_o;
        o.mem_to_reg = mem_to_reg_o;
        o.illegal    = illegal_o;
        o.bus_err    = bus_err_o;
        return o;
    endfunction

    // Write strobes and flags are always checked; selects only when given a mask bit.
    function automatic obs_t strobe_mask();
        obs_t m = '0;
        m.mem_req = 1'b1; m.mem_we = 1'b1; m.ir_we = 1'b1; m.pc_we = 1'b1;
        m.reg_we  = 1'b1; m.illegal = 1'b1; m.bus_err = 1'b1;
        return m;
    endfunction

    task automatic push(input obs_t v, input obs_t m);
        exp_t e;
        e.v = v;
        e.m = m | strobe_mask();
        exp_q.push_back(e);
    endtask

    // {valid, alu code} for an R-type function field
    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        case (f)
            6'h20:   return 4'b1_010;
            6'h22:   return 4'b1_110;
            6'h24:   return 4'b1_000;
            6'h25:   return 4'b1_001;
            6'h2A:   return 4'b1_111;
            default: return 4'b0_000;
        endcase
    endfunction

    // A memory request acked after d wait cycles, or abandoned by the watchdog.
    task automatic model_request(input obs_t v, input obs_t m, input int d, input bit is_fetch,
                                 output bit ok);
        obs_t last;
        if (T != 0 && d > T) begin
            for (int i = 0; i < T; i++) push(v, m);
            last = v;
            last.bus_err = 1'b1;
            push(last, m);
            push('0, '1);
            ok = 1'b0;
        end else begin
            for (int i = 0; i < d; i++) push(v, m);
            last = v;
            if (is_fetch) begin
                last.ir_we = 1'b1;
                last.pc_we = 1'b1;
            end
            push(last, m);
            ok = 1'b1;
        end
    endtask

    // Expected cycle-by-cycle controls for one instruction, starting at its fetch.
    task automatic model_instr(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                               input int fd, input int md);
        obs_t v, m;
        bit ok;
        logic [3:0] fa;
        v = '0; m = '0;
        v.mem_req = 1'b1; v.src_b = 2'b01; v.alu = 3'b010;
        m.iord = 1'b1; m.pc_src = 2'b11; m.src_a = 1'b1; m.src_b = 2'b11; m.alu = 3'b111;
        model_request(v, m, fd, 1'b1, ok);
        if (!ok) return;
        v = '0; m = '0;
        v.src_b = 2'b11; v.alu = 3'b010;
        m.src_a = 1'b1; m.src_b = 2'b11; m.alu = 3'b111;
        push(v, m);
        m = '0;
        m.src_a = 1'b1; m.src_b = 2'b11; m.alu = 3'b111;
        if (op == OP_LW || op == OP_SW) begin
            v = '0;
            v.src_a = 1'b1; v.src_b = 2'b10; v.alu = 3'b010;
            push(v, m);
            v = '0; m = '0;
            v.mem_req = 1'b1; v.iord = 1'b1; v.mem_we = (op == OP_SW);
            m.iord = 1'b1;
            model_request(v, m, md, 1'b0, ok);
            if (!ok || op == OP_SW) return;
            v = '0; m = '0;
            v.reg_we = 1'b1; v.mem_to_reg = 1'b1;
            m.reg_dst = 1'b1; m.mem_to_reg = 1'b1;
            push(v, m);
        end else if (op == OP_RTYPE) begin
            fa = funct_alu(funct);
            v = '0;
            v.src_a = 1'b1; v.alu = fa[2:0];
            if (!fa[3]) m.alu = 3'b000;
            push(v, m);
            v = '0; m = '0;
            if (fa[3]) begin
                v.reg_we = 1'b1; v.reg_dst = 1'b1;
                m.reg_dst = 1'b1; m.mem_to_reg = 1'b1;
            end else begin
                v.illegal = 1'b1;
            end
            push(v, m);
        end else if (op == OP_ADDI) begin
            v = '0;
            v.src_a = 1'b1; v.src_b = 2'b10; v.alu = 3'b010;
            push(v, m);
            v = '0; m = '0;
            v.reg_we = 1'b1;
            m.reg_dst = 1'b1;
            push(v, m);
        end else if (op == OP_BEQ) begin
            v = '0;
            v.src_a = 1'b1; v.alu = 3'b110; v.pc_src = 2'b01; v.pc_we = zero;
            m.pc_src = 2'b11;
            push(v, m);
        end else if (op == OP_J) begin
            v = '0; m = '0;
            v.pc_src = 2'b10; v.pc_we = 1'b1;
            m.pc_src = 2'b11;
            push(v, m);
        end else begin
            v = '0; m = '0;
            v.illegal = 1'b1;
            push(v, m);
        end
    endtask

    // Drive one instruction from a FETCH negedge until the next fresh fetch begins.
    // The memory acks request n after its chosen number of wait cycles.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                             input int fd, input int md);
        int cyc   = 0;
        int waits = 0;
        int req_n = 0;
        int dly;
        bit fetch;
        bit prev_fetch = 1'b0;
        got_q.delete();
        op_i = op; funct_i = funct; zero_i = zero;
        while (1'b1) begin
            fetch = mem_req_o && !iord_o;
            if (cyc > 0 && fetch && !prev_fetch) break;
            if (cyc >= 64) begin
                total++;
                bad++;
                $display("FAIL instr_bound: no new fetch after %0d cycles", cyc);
                break;
            end
            dly = (req_n == 0) ? fd : (req_n == 1) ? md : 0;
            mem_ack_i = mem_req_o && (waits == dly);
            #1;
            got_q.push_back(sample());
            if (mem_req_o) begin
                if (mem_ack_i || bus_err_o) begin
                    req_n++;
                    waits = 0;
                end else begin
                    waits++;
                end
            end
            prev_fetch = fetch;
            cyc++;
            @(negedge clk);
        end
        mem_ack_i = 1'b0;
    endtask

    task automatic compare_instr(input string name);
        int n;
        check($sformatf("%s len", name), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s c%0d", name, i),
                  32'(got_q[i] & exp_q[i].m), 32'(exp_q[i].v & exp_q[i].m));
        end
        exp_q.delete();
    endtask

    function automatic int rand_delay();
        if ($urandom_range(0, 15) == 0) return int'(T) + 1 + int'($urandom_range(0, 2));
        return int'($urandom_range(0, T));
    endfunction

    initial begin
        // op, funct, zero, fetch delay, mem delay, expected cycles
        vecs[0]  = '{OP_RTYPE, FN_ADD, 1'b0, 0, 0, 4};
        vecs[1]  = '{OP_RTYPE, FN_SUB, 1'b0, 2, 0, 6};
        vecs[2]  = '{OP_RTYPE, FN_AND, 1'b0, 0, 0, 4};
        vecs[3]  = '{OP_RTYPE, FN_OR,  1'b0, 0, 0, 4};
        vecs[4]  = '{OP_RTYPE, FN_SLT, 1'b0, 0, 0, 4};
        vecs[5]  = '{OP_LW,    6'h00,  1'b0, 0, 0, 5};
        vecs[6]  = '{OP_LW,    6'h00,  1'b0, 0, 3, 8};
        vecs[7]  = '{OP_SW,    6'h00,  1'b0, 0, 0, 4};
        vecs[8]  = '{OP_SW,    6'h00,  1'b0, 1, 2, 7};
        vecs[9]  = '{OP_ADDI,  6'h00,  1'b0, 0, 0, 4};
        vecs[10] = '{OP_BEQ,   6'h00,  1'b1, 0, 0, 3};
        vecs[11] = '{OP_BEQ,   6'h00,  1'b0, 0, 0, 3};
        vecs[12] = '{OP_J,     6'h00,  1'b0, 0, 0, 3};
        vecs[13] = '{6'h3F,    6'h00,  1'b0, 0, 0, 3};
        vecs[14] = '{OP_RTYPE, 6'h07,  1'b0, 0, 0, 4};
        vecs[15] = '{OP_J,     6'h00,  1'b0, 4, 0, 7};
        vecs[16] = '{OP_RTYPE, FN_ADD, 1'b0, 5, 0, 6};
        vecs[17] = '{OP_LW,    6'h00,  1'b0, 0, 5, 9};
        vecs[18] = '{OP_SW,    6'h00,  1'b0, 0, 4, 8};

        reset = 1'b1; op_i = '0; funct_i = '0; zero_i = 1'b0; mem_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst state", 32'(state_o), 32'(ST_IDLE));
        check("rst outputs", 32'(sample()), 32'h0);
        reset = 1'b0;
        #1;
        check("post-rst idle", 32'(state_o), 32'(ST_IDLE));
        check("post-rst no req", 32'(mem_req_o), 32'h0);
        @(negedge clk);
        check("first fetch req", 32'({mem_req_o, iord_o}), 32'b10);

        // Directed table
        for (int i = 0; i < 19; i++) begin
            model_instr(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].fd, vecs[i].md);
            run_instr(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].fd, vecs[i].md);
            check($sformatf("vec%0d cycles", i), got_q.size(), vecs[i].cycles);
            compare_instr($sformatf("vec%0d", i));
        end

        // Reset while a store waits for ack
        op_i = OP_SW; funct_i = '0;
        mem_ack_i = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("sw req before rst", 32'({mem_req_o, mem_we_o, iord_o}), 32'b111);
        #2 reset = 1'b1;
        #1;
        check("sw rst drops req", 32'({mem_req_o, mem_we_o}), 32'b00);
        check("sw rst state", 32'(state_o), 32'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("sw rst idle", 32'(state_o), 32'(ST_IDLE));
        @(negedge clk);
        check("sw rst next fetch", 32'({mem_req_o, mem_we_o, iord_o}), 32'b100);

        // Randomised instruction stream
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op, fn;
            logic z;
            int fd, md;
            int k;
            k  = int'($urandom_range(0, 6));
            op = (k < 6) ? legal_ops[k] : bad_ops[$urandom_range(0, 3)];
            fn = functs[$urandom_range(0, 6)];
            z  = 1'($urandom_range(0, 1));
            fd = rand_delay();
            md = rand_delay();
            model_instr(op, fn, z, fd, md);
            run_instr(op, fn, z, fd, md);
            compare_instr($sformatf("rnd%0d op%0h fn%0h", n, op, fn));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
